// File: rtl/painterengine_gpu_writer_scheduler_pkg.sv
// rtl/painterengine_gpu_writer_scheduler_pkg.sv - shared types and constants for the GPU writer scheduler
package painterengine_gpu_writer_scheduler_pkg;

  localparam int NUM_CH = 4;
  localparam int LANE_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_GRANT    = 3'd2,
    ST_BUSY     = 3'd3,
    ST_COMPLETE = 3'd4
  } state_e;

  // Codes 1..4 are shared with the writer; PARAM doubles as the local reject code.
  typedef enum logic [2:0] {
    ERR_OK      = 3'd0,
    ERR_WR_1    = 3'd1,
    ERR_PARAM   = 3'd2,
    ERR_WR_3    = 3'd3,
    ERR_WR_4    = 3'd4,
    ERR_TIMEOUT = 3'd5
  } err_e;

  function automatic logic [NUM_CH-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/painterengine_gpu_rr_arbiter4.sv
// rtl/painterengine_gpu_rr_arbiter4.sv - combinational 4-way round-robin pick starting after pointer
module painterengine_gpu_rr_arbiter4
  import painterengine_gpu_writer_scheduler_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        pointer,
  output logic              grant_valid,
  output logic [1:0]        grant_index,
  output logic [NUM_CH-1:0] grant
);

  logic [1:0] idx;

  // Scan from lowest to highest priority so the closest request after pointer wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_index = 2'd0;
    idx         = 2'd0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = pointer + 2'(i);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_index = idx;
      end
    end
    grant = grant_valid ? onehot4(grant_index) : '0;
  end

endmodule

// File: rtl/painterengine_gpu_writer_scheduler.sv
// rtl/painterengine_gpu_writer_scheduler.sv - round-robin job scheduler for the shared GPU DMA writer
module painterengine_gpu_writer_scheduler
  import painterengine_gpu_writer_scheduler_pkg::*;
#(
  parameter int PARAM_TIMEOUT_CYCLES = 1048576,
  parameter int PARAM_RESET_HOLD     = 2
) (
  input  logic                 i_wire_clock,
  input  logic                 i_wire_reset,
  input  logic [NUM_CH-1:0]    i_wire_req,
  input  logic [127:0]         i_wire_address,
  input  logic [127:0]         i_wire_length,
  output logic [NUM_CH-1:0]    o_wire_ack,
  output logic [NUM_CH-1:0]    o_wire_done,
  output logic [NUM_CH-1:0]    o_wire_error,
  output logic [2:0]           o_wire_error_type,
  output logic                 o_wire_busy,
  output logic                 o_wire_writer_resetn,
  output logic [NUM_CH-1:0]    o_wire_writer_router,
  output logic [127:0]         o_wire_writer_address,
  output logic [127:0]         o_wire_writer_length,
  input  logic                 i_wire_writer_done,
  input  logic                 i_wire_writer_error,
  input  logic [2:0]           i_wire_writer_error_type
);

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        chan_q, chan_d;
  logic [LANE_W-1:0] addr_q, addr_d;
  logic [LANE_W-1:0] len_q, len_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [2:0]        status_q, status_d;
  logic              is_err_q, is_err_d;
  logic [NUM_CH-1:0] router_q, router_d;
  logic              resetn_q, resetn_d;
  logic              busy_q, busy_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] error_q, error_d;
  logic [2:0]        etype_q, etype_d;

  logic              arb_valid;
  logic [1:0]        arb_index;
  logic [NUM_CH-1:0] arb_grant;

  painterengine_gpu_rr_arbiter4 u_arb (
    .req         (i_wire_req),
    .pointer     (ptr_q),
    .grant_valid (arb_valid),
    .grant_index (arb_index),
    .grant       (arb_grant)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    chan_d   = chan_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    is_err_d = is_err_q;
    router_d = router_q;
    done_d   = '0;
    error_d  = '0;
    etype_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          chan_d   = arb_index;
          ptr_d    = arb_index;
          addr_d   = i_wire_address[{arb_index, 5'd0} +: LANE_W];
          len_d    = i_wire_length[{arb_index, 5'd0} +: LANE_W];
          status_d = ERR_OK;
          is_err_d = 1'b0;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Bad parameters never reach the writer: it stays in reset throughout.
        if (addr_q[1:0] != 2'b00 || len_q == '0) begin
          status_d = ERR_PARAM;
          is_err_d = 1'b1;
          state_d  = ST_COMPLETE;
        end else begin
          cnt_d    = 32'(PARAM_RESET_HOLD);
          router_d = onehot4(chan_q);
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (cnt_q == 32'd1) begin
          cnt_d   = '0;
          state_d = ST_BUSY;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_BUSY: begin
        if (i_wire_writer_error) begin
          status_d = i_wire_writer_error_type;
          is_err_d = 1'b1;
          state_d  = ST_COMPLETE;
        end else if (i_wire_writer_done) begin
          status_d = ERR_OK;
          is_err_d = 1'b0;
          state_d  = ST_COMPLETE;
        end else if (cnt_q == 32'(PARAM_TIMEOUT_CYCLES - 1)) begin
          status_d = ERR_TIMEOUT;
          is_err_d = 1'b1;
          state_d  = ST_COMPLETE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_COMPLETE: begin
        router_d = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        router_d = '0;
        state_d  = ST_IDLE;
      end
    endcase

    // Status outputs are registered off the next state so they line up with COMPLETE.
    resetn_d = (state_d == ST_BUSY);
    busy_d   = (state_d != ST_IDLE);
    if (state_d == ST_COMPLETE) begin
      if (is_err_d) begin
        error_d = onehot4(chan_q);
        etype_d = status_d;
      end else begin
        done_d = onehot4(chan_q);
      end
    end
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 2'd3;
      chan_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      status_q <= ERR_OK;
      is_err_q <= 1'b0;
      router_q <= '0;
      resetn_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= '0;
      error_q  <= '0;
      etype_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      chan_q   <= chan_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      is_err_q <= is_err_d;
      router_q <= router_d;
      resetn_q <= resetn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      etype_q  <= etype_d;
    end
  end

  // Ack is decided in the IDLE cycle itself, so it is the only combinational output.
  assign o_wire_ack           = (state_q == ST_IDLE && !i_wire_reset) ? arb_grant : '0;
  assign o_wire_done          = done_q;
  assign o_wire_error         = error_q;
  assign o_wire_error_type    = etype_q;
  assign o_wire_busy          = busy_q;
  assign o_wire_writer_resetn = resetn_q;
  assign o_wire_writer_router = router_q;

  always_comb begin
    o_wire_writer_address = '0;
    o_wire_writer_length  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (router_q[n]) begin
        o_wire_writer_address[n*LANE_W +: LANE_W] = addr_q;
        o_wire_writer_length[n*LANE_W +: LANE_W]  = len_q;
      end
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_writer_scheduler.sv
// tb/tb_painterengine_gpu_writer_scheduler.sv - self-checking bench for the GPU writer scheduler
module tb_painterengine_gpu_writer_scheduler;

  localparam int TO   = 1000;
  localparam int HOLD = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [127:0] addr_bus = '0;
  logic [127:0] len_bus = '0;
  logic         wdone = 1'b0;
  logic         werr = 1'b0;
  logic [2:0]   wtype = '0;
  logic [3:0]   o_ack, o_done, o_error, w_router;
  logic [2:0]   o_etype;
  logic         o_busy, w_resetn;
  logic [127:0] w_addr, w_len;

  painterengine_gpu_writer_scheduler #(
    .PARAM_TIMEOUT_CYCLES (TO),
    .PARAM_RESET_HOLD     (HOLD)
  ) dut (
    .i_wire_clock             (clk),
    .i_wire_reset             (rst),
    .i_wire_req               (req),
    .i_wire_address           (addr_bus),
    .i_wire_length            (len_bus),
    .o_wire_ack               (o_ack),
    .o_wire_done              (o_done),
    .o_wire_error             (o_error),
    .o_wire_error_type        (o_etype),
    .o_wire_busy              (o_busy),
    .o_wire_writer_resetn     (w_resetn),
    .o_wire_writer_router     (w_router),
    .o_wire_writer_address    (w_addr),
    .o_wire_writer_length     (w_len),
    .i_wire_writer_done       (wdone),
    .i_wire_writer_error      (werr),
    .i_wire_writer_error_type (wtype)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] chan;
    logic       err;
    logic [2:0] etype;
  } exp_t;
  exp_t sb[$];

  // action: 0 never respond, 1 done, 2 error, 3 done+error, 4 expect local reject
  typedef struct {
    int          chan;
    logic [31:0] addr;
    logic [31:0] len;
    int          action;
    int          delay;
    logic [2:0]  wtype;
    logic        err;
    logic [2:0]  etype;
  } vec_t;
  vec_t vecs[8];

  int         m_action = 1;
  int         m_delay = 1;
  logic [2:0] m_type = '0;
  int         wcnt = 0;
  int         done_cyc = -1;
  int         release_count = 0;

  function automatic logic [3:0] oh(input int c);
    return 4'b0001 << c;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Writer model: counts cycles since release and responds after m_delay.
  always @(negedge clk) begin
    if (!w_resetn) begin
      wdone = 1'b0;
      werr  = 1'b0;
      wtype = '0;
      wcnt  = 0;
    end else begin
      if (wcnt == 0) release_count++;
      wcnt++;
      if (wcnt == m_delay) begin
        done_cyc = cyc;
        case (m_action)
          1: wdone = 1'b1;
          2: begin werr = 1'b1; wtype = m_type; end
          3: begin wdone = 1'b1; werr = 1'b1; wtype = m_type; end
          default: ;
        endcase
      end
    end
  end

  // Scoreboard: every completion pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (!rst && (o_done != 0 || o_error != 0)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse got done=%0h error=%0h exp none", o_done, o_error);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_done", o_done, e.err ? 4'b0 : oh(e.chan));
        check("pulse_error", o_error, e.err ? oh(e.chan) : 4'b0);
        if (e.err) check("pulse_type", o_etype, e.etype);
      end
    end
  end

  task automatic wait_ack(output logic [3:0] a, output int ac);
    a  = '0;
    ac = -1;
    for (int k = 0; k < 2000; k++) begin
      #1;
      if (o_ack != 0) begin
        a  = o_ack;
        ac = cyc;
        return;
      end
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL ack_timeout got=none exp=ack");
  endtask

  task automatic wait_pulse(input int ch, output int pc, output int rel, output logic [3:0] r,
                            output logic [127:0] ad, output logic [127:0] ln,
                            output logic rn_at, output logic busy_at);
    logic saw;
    saw = 1'b0; pc = -1; rel = -1; r = '0; ad = '0; ln = '0; rn_at = 1'b1; busy_at = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (w_resetn && !saw) begin
        saw = 1'b1; rel = cyc; r = w_router; ad = w_addr; ln = w_len;
      end
      if (o_done[ch] || o_error[ch]) begin
        pc = cyc; rn_at = w_resetn; busy_at = o_busy;
        req[ch] = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL pulse_timeout got=none exp=pulse ch%0d", ch);
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] a, r;
    logic [127:0] ad, ln, ea, el;
    logic rn_at, busy_at;
    int ac, pc, rel, rc0;
    m_action = v.action; m_delay = v.delay; m_type = v.wtype;
    @(negedge clk);
    addr_bus[v.chan*32 +: 32] = v.addr;
    len_bus[v.chan*32 +: 32]  = v.len;
    req[v.chan] = 1'b1;
    wait_ack(a, ac);
    check("ack", a, oh(v.chan));
    sb.push_back('{2'(v.chan), v.err, v.etype});
    rc0 = release_count;
    wait_pulse(v.chan, pc, rel, r, ad, ln, rn_at, busy_at);
    if (v.action == 4) begin
      check("reject_latency", 128'(pc - ac), 128'(2));
      check("reject_no_release", 128'(release_count - rc0), 128'(0));
    end else begin
      ea = '0; el = '0;
      ea[v.chan*32 +: 32] = v.addr;
      el[v.chan*32 +: 32] = v.len;
      check("release_latency", 128'(rel - ac), 128'(2 + HOLD));
      check("router", r, oh(v.chan));
      check("addr_lane", ad, ea);
      check("len_lane", ln, el);
      if (v.action == 0) begin
        check("watchdog_latency", 128'(pc - rel), 128'(TO));
        check("resetn_after_wd", rn_at, 1'b0);
      end else begin
        check("status_latency", 128'(pc - done_cyc), 128'(1));
      end
    end
    check("busy_at_pulse", busy_at, 1'b1);
    @(negedge clk);
    check("busy_after", o_busy, 1'b0);
    check("router_cleared", w_router, 4'b0);
  endtask

  task automatic run_batch(input logic [3:0] mask, input int n, input logic [7:0] order);
    logic [3:0] a, r;
    logic [127:0] ad, ln;
    logic rn_at, busy_at;
    int ac, pc, rel;
    logic [1:0] ch;
    m_action = 1; m_delay = 5;
    req = req | mask;
    for (int k = 0; k < n; k++) begin
      ch = order[k*2 +: 2];
      wait_ack(a, ac);
      check("rr_order", a, oh(int'(ch)));
      sb.push_back('{ch, 1'b0, 3'b000});
      wait_pulse(int'(ch), pc, rel, r, ad, ln, rn_at, busy_at);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {o_ack, o_done, o_error, o_etype, o_busy, w_resetn, w_router}, '0);
    check({name, "_addr"}, w_addr, '0);
    check({name, "_len"}, w_len, '0);
  endtask

  initial begin
    logic [3:0] a;
    int ac;

    vecs[0] = '{2, 32'h1000, 32'd64, 1, 100, 3'd0, 1'b0, 3'd0};
    vecs[1] = '{1, 32'h2000, 32'd0,  4, 1,   3'd0, 1'b1, 3'b010};
    vecs[2] = '{1, 32'h1002, 32'd16, 4, 1,   3'd0, 1'b1, 3'b010};
    vecs[3] = '{3, 32'h3000, 32'd8,  2, 20,  3'b100, 1'b1, 3'b100};
    vecs[4] = '{0, 32'h4000, 32'd4,  1, 5,   3'd0, 1'b0, 3'd0};
    vecs[5] = '{1, 32'h5004, 32'd1,  3, 3,   3'b001, 1'b1, 3'b001};
    vecs[6] = '{3, 32'h6000, 32'd32, 2, 1,   3'b011, 1'b1, 3'b011};
    vecs[7] = '{0, 32'h7000, 32'd2,  0, 1,   3'd0, 1'b1, 3'b101};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Contention straight out of reset, then a partial re-request.
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      addr_bus[n*32 +: 32] = 32'h100 * (n + 1);
      len_bus[n*32 +: 32]  = 32'd8;
    end
    req = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    check("ack_gated_in_reset", o_ack, 4'b0);
    @(negedge clk);
    rst = 1'b0;
    run_batch(4'b1111, 4, {2'd3, 2'd2, 2'd1, 2'd0});
    run_batch(4'b0101, 2, {2'd0, 2'd0, 2'd2, 2'd0});

    // Reset 10 cycles into BUSY aborts silently and restores channel 0 priority.
    m_action = 0;
    @(negedge clk);
    req[1] = 1'b1;
    wait_ack(a, ac);
    check("mid_ack", a, 4'b0010);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (w_resetn) break;
    end
    check("mid_release_seen", w_resetn, 1'b1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    req = 4'b1111;
    @(negedge clk);
    check_all_zero("mid_reset_hold");
    rst = 1'b0;
    wait_ack(a, ac);
    check("post_reset_first", a, 4'b0001);
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
